// File: rtl/femtorv_bus_pkg.sv
// Shared types and constants for the two-master FemtoRV bus arbiter.
// Latency: none (definitions only). Backpressure: none.
package femtorv_bus_pkg;

    localparam int MASK_W         = 4;
    localparam int DEF_ADDR_WIDTH = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } arb_state_t;

    function automatic logic is_req(input logic rstrb, input logic [MASK_W-1:0] wmask);
        return rstrb | (|wmask);
    endfunction

endpackage

// File: rtl/femtorv_bus_arbiter_if.sv
// One native FemtoRV bus link: strobe/mask requests forward, data and busy back.
// Latency: wires only. Backpressure: rbusy/wbusy held by the responder until completion.
interface femtorv_bus_arbiter_if
    import femtorv_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [MASK_W-1:0]     wmask;
    logic                  rstrb;
    logic [31:0]           rdata;
    logic                  rbusy;
    logic                  wbusy;

    modport master (output addr, wdata, wmask, rstrb, input rdata, rbusy, wbusy);
    modport slave  (input addr, wdata, wmask, rstrb, output rdata, rbusy, wbusy);
endinterface

// File: rtl/femtorv_req_buffer.sv
// Single-entry holding slot for a request that lost arbitration.
// Latency: captured at end of request cycle. Backpressure: owner masks new requests while valid.
module femtorv_req_buffer
    import femtorv_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0]           in_wdata,
    input  logic [MASK_W-1:0]     in_wmask,
    input  logic                  in_is_read,
    output logic                  vld,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           wdata,
    output logic [MASK_W-1:0]     wmask,
    output logic                  is_read
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld     <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            wmask   <= '0;
            is_read <= 1'b0;
        end else if (cap) begin
            vld     <= 1'b1;
            addr    <= in_addr;
            wdata   <= in_wdata;
            wmask   <= in_wmask;
            is_read <= in_is_read;
        end else if (clr) begin
            vld     <= 1'b0;
        end
    end
endmodule

// File: rtl/femtorv_bus_arbiter.sv
// Round-robin share of one FemtoRV memory port between M0 (core) and M1 (loader/DMA).
// Latency: new request forwarded same cycle when idle; loser replays the cycle after completion.
// Backpressure: loser sees busy from the cycle after its request until its own completion.
module femtorv_bus_arbiter
    import femtorv_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit RR_INIT    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    femtorv_bus_arbiter_if.slave  m0,
    femtorv_bus_arbiter_if.slave  m1,
    femtorv_bus_arbiter_if.master s
);
    arb_state_t            state, state_nxt;
    logic                  owner, rr;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [31:0]           hold_wdata;

    logic [ADDR_WIDTH-1:0] n_addr  [2];
    logic [31:0]           n_wdata [2];
    logic [MASK_W-1:0]     n_wmask [2];
    logic                  n_rd    [2];
    logic                  n_raw   [2];
    logic                  n_req   [2];
    logic                  own_act [2];

    logic [ADDR_WIDTH-1:0] b_addr  [2];
    logic [31:0]           b_wdata [2];
    logic [MASK_W-1:0]     b_wmask [2];
    logic                  b_rd    [2];
    logic                  b_vld   [2];
    logic                  cap     [2];
    logic                  clr     [2];

    logic                  complete, grant, win, g_rd;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [31:0]           g_wdata;
    logic [MASK_W-1:0]     g_wmask;

    assign n_addr[0]  = m0.addr;
    assign n_addr[1]  = m1.addr;
    assign n_wdata[0] = m0.wdata;
    assign n_wdata[1] = m1.wdata;
    assign n_wmask[0] = m0.wmask;
    assign n_wmask[1] = m1.wmask;
    // A nonzero mask makes it a write even if rstrb pulses alongside.
    assign n_rd[0]    = ~|m0.wmask;
    assign n_rd[1]    = ~|m1.wmask;
    assign n_raw[0]   = reset & is_req(m0.rstrb, m0.wmask);
    assign n_raw[1]   = reset & is_req(m1.rstrb, m1.wmask);

    assign complete   = ((state == ST_RD_WAIT) & ~s.rbusy) | ((state == ST_WR_WAIT) & ~s.wbusy);
    assign own_act[0] = (state != ST_IDLE) & (owner == 1'b0) & ~complete;
    assign own_act[1] = (state != ST_IDLE) & (owner == 1'b1) & ~complete;

    // Requests from a master that is already pending are protocol violations and dropped.
    assign n_req[0]   = n_raw[0] & ~b_vld[0] & ~own_act[0];
    assign n_req[1]   = n_raw[1] & ~b_vld[1] & ~own_act[1];

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win       = 1'b0;
        g_rd      = 1'b0;
        g_addr    = '0;
        g_wdata   = '0;
        g_wmask   = '0;
        case (state)
            ST_IDLE: begin
                if (b_vld[0] | n_req[0] | b_vld[1] | n_req[1]) begin
                    grant = 1'b1;
                    if ((b_vld[0] | n_req[0]) & (b_vld[1] | n_req[1])) win = ~rr;
                    else                                               win = b_vld[1] | n_req[1];
                end
            end
            ST_RD_WAIT: if (!s.rbusy) state_nxt = ST_IDLE;
            ST_WR_WAIT: if (!s.wbusy) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (grant) begin
            if (b_vld[win]) begin
                g_rd    = b_rd[win];
                g_addr  = b_addr[win];
                g_wdata = b_wdata[win];
                g_wmask = b_wmask[win];
            end else begin
                g_rd    = n_rd[win];
                g_addr  = n_addr[win];
                g_wdata = n_wdata[win];
                g_wmask = n_wmask[win];
            end
            state_nxt = g_rd ? ST_RD_WAIT : ST_WR_WAIT;
        end
    end

    assign cap[0] = n_req[0] & ~(grant & ~win);
    assign cap[1] = n_req[1] & ~(grant & win);
    assign clr[0] = grant & ~win & b_vld[0];
    assign clr[1] = grant & win & b_vld[1];

    femtorv_req_buffer #(.ADDR_WIDTH(ADDR_WIDTH)) u_buf0 (
        .clk(clk), .reset(reset), .cap(cap[0]), .clr(clr[0]),
        .in_addr(n_addr[0]), .in_wdata(n_wdata[0]), .in_wmask(n_wmask[0]), .in_is_read(n_rd[0]),
        .vld(b_vld[0]), .addr(b_addr[0]), .wdata(b_wdata[0]), .wmask(b_wmask[0]), .is_read(b_rd[0])
    );

    femtorv_req_buffer #(.ADDR_WIDTH(ADDR_WIDTH)) u_buf1 (
        .clk(clk), .reset(reset), .cap(cap[1]), .clr(clr[1]),
        .in_addr(n_addr[1]), .in_wdata(n_wdata[1]), .in_wmask(n_wmask[1]), .in_is_read(n_rd[1]),
        .vld(b_vld[1]), .addr(b_addr[1]), .wdata(b_wdata[1]), .wmask(b_wmask[1]), .is_read(b_rd[1])
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            rr         <= RR_INIT;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner      <= win;
                rr         <= win;
                hold_addr  <= g_addr;
                hold_wdata <= g_wdata;
            end
        end
    end

    assign s.rstrb  = grant & g_rd;
    assign s.wmask  = (grant & ~g_rd) ? g_wmask : '0;
    assign s.addr   = grant ? g_addr : hold_addr;
    assign s.wdata  = grant ? g_wdata : hold_wdata;

    // Buffered masters stay busy through their replay cycle; owners follow the slave.
    assign m0.rbusy = (b_vld[0] & b_rd[0])  | ((state == ST_RD_WAIT) & (owner == 1'b0) & s.rbusy);
    assign m0.wbusy = (b_vld[0] & ~b_rd[0]) | ((state == ST_WR_WAIT) & (owner == 1'b0) & s.wbusy);
    assign m1.rbusy = (b_vld[1] & b_rd[1])  | ((state == ST_RD_WAIT) & (owner == 1'b1) & s.rbusy);
    assign m1.wbusy = (b_vld[1] & ~b_rd[1]) | ((state == ST_WR_WAIT) & (owner == 1'b1) & s.wbusy);
    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;

endmodule

// File: tb/tb_femtorv_bus_arbiter.sv
// Vector table plus directed sequences; slave-side scoreboard checks every issued strobe.
module tb_femtorv_bus_arbiter;
    import femtorv_bus_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stall = 0;
    int   scnt;
    logic s_rd_p, s_wr_p;
    logic [31:0] s_rdata_val = 32'h0;

    femtorv_bus_arbiter_if #(.ADDR_WIDTH(24)) m0_bus ();
    femtorv_bus_arbiter_if #(.ADDR_WIDTH(24)) m1_bus ();
    femtorv_bus_arbiter_if #(.ADDR_WIDTH(24)) s_bus ();

    femtorv_bus_arbiter #(.ADDR_WIDTH(24), .RR_INIT(1'b0)) dut (
        .clk(clk), .reset(rst_n), .m0(m0_bus), .m1(m1_bus), .s(s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: busy for 'stall' cycles after each strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= 0; s_rd_p <= 1'b0; s_wr_p <= 1'b0;
        end else if (s_bus.rstrb || s_bus.wmask != 4'h0) begin
            scnt <= stall; s_rd_p <= s_bus.rstrb; s_wr_p <= (s_bus.wmask != 4'h0);
        end else if (scnt != 0) begin
            scnt <= scnt - 1;
        end
    end
    assign s_bus.rbusy = s_rd_p && (scnt != 0);
    assign s_bus.wbusy = s_wr_p && (scnt != 0);
    assign s_bus.rdata = s_rdata_val;

    typedef struct packed {
        logic        rd;
        logic [3:0]  wmask;
        logic [23:0] addr;
        logic [31:0] wdata;
    } txn_t;
    txn_t sb[$];
    txn_t mon_got, mon_exp;

    typedef struct {
        logic r0; logic [3:0] w0; logic [23:0] a0; logic [31:0] d0;
        logic r1; logic [3:0] w1; logic [23:0] a1; logic [31:0] d1;
        logic e_rstrb; logic [3:0] e_wmask; logic [23:0] e_addr; logic [31:0] e_wdata;
        logic [1:0] e_b0; logic [1:0] e_b1;
        int loser;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic rd, input logic [3:0] wm, input logic [23:0] a, input logic [31:0] d);
        txn_t t;
        t.rd = rd; t.wmask = wm; t.addr = a; t.wdata = rd ? 32'h0 : d;
        sb.push_back(t);
    endtask

    task automatic drive(input int m, input logic rd, input logic [3:0] wm, input logic [23:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_bus.rstrb = rd; m0_bus.wmask = wm; m0_bus.addr = a; m0_bus.wdata = d;
        end else begin
            m1_bus.rstrb = rd; m1_bus.wmask = wm; m1_bus.addr = a; m1_bus.wdata = d;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        m0_bus.rstrb = 1'b0; m0_bus.wmask = 4'h0;
        m1_bus.rstrb = 1'b0; m1_bus.wmask = 4'h0;
    endtask

    task automatic do_reset();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        rst_n = 1'b0;
        stall = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();
    endtask

    // Strobe monitor and master-side protocol watch.
    always @(negedge clk) begin
        if (rst_n && (s_bus.rstrb || s_bus.wmask != 4'h0)) begin
            mon_got.rd    = s_bus.rstrb && s_bus.wmask == 4'h0;
            mon_got.wmask = s_bus.wmask;
            mon_got.addr  = s_bus.addr;
            mon_got.wdata = mon_got.rd ? 32'h0 : s_bus.wdata;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_unexpected: got strobe %0h, expected none (t=%0t)", mon_got, $time);
            end else begin
                mon_exp = sb.pop_front();
                chk("sb_txn", 64'(mon_got), 64'(mon_exp));
            end
        end
        if (rst_n && (m0_bus.rstrb || m0_bus.wmask != 4'h0))
            chk("m0_proto_busy", {63'd0, m0_bus.rbusy | m0_bus.wbusy}, 64'd0);
        if (rst_n && (m1_bus.rstrb || m1_bus.wmask != 4'h0))
            chk("m1_proto_busy", {63'd0, m1_bus.rbusy | m1_bus.wbusy}, 64'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        bit p0, p1, i0, i1;
        vt[0] = '{1'b1, 4'h0, 24'h000100, 32'h0, 1'b0, 4'h0, 24'h0, 32'h0,
                  1'b1, 4'h0, 24'h000100, 32'h0, 2'b00, 2'b00, -1};
        vt[1] = '{1'b0, 4'h0, 24'h0, 32'h0, 1'b0, 4'b0011, 24'h000204, 32'h11112222,
                  1'b0, 4'b0011, 24'h000204, 32'h11112222, 2'b00, 2'b00, -1};
        vt[2] = '{1'b1, 4'h0, 24'h000010, 32'h0, 1'b0, 4'hF, 24'h000020, 32'hAAAA5555,
                  1'b1, 4'h0, 24'h000010, 32'h0, 2'b00, 2'b01, 1};
        vt[3] = '{1'b0, 4'b1000, 24'h000030, 32'h33333333, 1'b1, 4'h0, 24'h000040, 32'h0,
                  1'b0, 4'b1000, 24'h000030, 32'h33333333, 2'b00, 2'b10, 1};
        vt[4] = '{1'b1, 4'b0100, 24'h000050, 32'h55555555, 1'b0, 4'h0, 24'h0, 32'h0,
                  1'b0, 4'b0100, 24'h000050, 32'h55555555, 2'b00, 2'b00, -1};
        vt[5] = '{1'b1, 4'h0, 24'h000060, 32'h0, 1'b1, 4'h0, 24'h000070, 32'h0,
                  1'b1, 4'h0, 24'h000070, 32'h0, 2'b10, 2'b00, 0};
        vt[6] = '{1'b0, 4'h0, 24'h0, 32'h0, 1'b0, 4'h0, 24'h0, 32'h0,
                  1'b0, 4'h0, 24'h000060, 32'h0, 2'b00, 2'b00, -1};
        vt[7] = '{1'b0, 4'h0, 24'h0, 32'h0, 1'b0, 4'hF, 24'hFFFFFC, 32'hFFFF0000,
                  1'b0, 4'hF, 24'hFFFFFC, 32'hFFFF0000, 2'b00, 2'b00, -1};
        vt[8] = '{1'b0, 4'b0001, 24'h000080, 32'h80808080, 1'b0, 4'b0010, 24'h000090, 32'h90909090,
                  1'b0, 4'b0001, 24'h000080, 32'h80808080, 2'b00, 2'b01, 1};
        vt[9] = '{1'b1, 4'h0, 24'h0000A0, 32'h0, 1'b0, 4'b1000, 24'h0000B0, 32'hB0B0B0B0,
                  1'b1, 4'h0, 24'h0000A0, 32'h0, 2'b00, 2'b01, 1};

        rst_n = 1'b0;
        drive(0, 1'b0, 4'h0, 24'h0, 32'h0);
        drive(1, 1'b0, 4'h0, 24'h0, 32'h0);
        #3;
        chk("rst_s_rstrb", {63'd0, s_bus.rstrb}, 64'd0);
        chk("rst_s_wmask", {60'd0, s_bus.wmask}, 64'd0);
        chk("rst_s_addr", {40'd0, s_bus.addr}, 64'd0);
        chk("rst_s_wdata", {32'd0, s_bus.wdata}, 64'd0);
        chk("rst_busy", {60'd0, m0_bus.rbusy, m0_bus.wbusy, m1_bus.rbusy, m1_bus.wbusy}, 64'd0);
        do_reset();

        // Vector table, slave answering immediately, rr history carried through.
        for (int v = 0; v < 10; v++) begin
            drive(0, vt[v].r0, vt[v].w0, vt[v].a0, vt[v].d0);
            drive(1, vt[v].r1, vt[v].w1, vt[v].a1, vt[v].d1);
            if (vt[v].e_rstrb || vt[v].e_wmask != 4'h0)
                push(vt[v].e_rstrb, vt[v].e_wmask, vt[v].e_addr, vt[v].e_wdata);
            if (vt[v].loser == 0) push(vt[v].w0 == 4'h0, vt[v].w0, vt[v].a0, vt[v].d0);
            if (vt[v].loser == 1) push(vt[v].w1 == 4'h0, vt[v].w1, vt[v].a1, vt[v].d1);
            #2;
            chk($sformatf("v%0d_s_rstrb", v), {63'd0, s_bus.rstrb}, {63'd0, vt[v].e_rstrb});
            chk($sformatf("v%0d_s_wmask", v), {60'd0, s_bus.wmask}, {60'd0, vt[v].e_wmask});
            chk($sformatf("v%0d_s_addr", v), {40'd0, s_bus.addr}, {40'd0, vt[v].e_addr});
            if (vt[v].e_wmask != 4'h0)
                chk($sformatf("v%0d_s_wdata", v), {32'd0, s_bus.wdata}, {32'd0, vt[v].e_wdata});
            next_cycle();
            #2;
            chk($sformatf("v%0d_busy", v), {60'd0, m0_bus.rbusy, m0_bus.wbusy, m1_bus.rbusy, m1_bus.wbusy},
                {60'd0, vt[v].e_b0, vt[v].e_b1});
            repeat (4) next_cycle();
        end

        // Solo read with immediate data.
        do_reset();
        s_rdata_val = 32'hDEADBEEF;
        drive(0, 1'b1, 4'h0, 24'h000100, 32'h0);
        push(1'b1, 4'h0, 24'h000100, 32'h0);
        #2 chk("t1_s_rstrb", {63'd0, s_bus.rstrb}, 64'd1);
        next_cycle();
        #2;
        chk("t1_m0_rbusy", {63'd0, m0_bus.rbusy}, 64'd0);
        chk("t1_m_rdata", {32'd0, m0_bus.rdata}, {32'd0, 32'hDEADBEEF});
        repeat (2) next_cycle();

        // Write against a 3-cycle slave stall.
        do_reset();
        stall = 3;
        drive(1, 1'b0, 4'b0011, 24'h000204, 32'h12345678);
        push(1'b0, 4'b0011, 24'h000204, 32'h12345678);
        #2 chk("t2_s_wmask", {60'd0, s_bus.wmask}, 64'h3);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            #2 chk($sformatf("t2_m1_wbusy_t%0d", k), {63'd0, m1_bus.wbusy}, {63'd0, k <= 3});
        end
        repeat (2) next_cycle();

        // Simultaneous requests: M1 wins with rr=0, M0 replays after completion.
        do_reset();
        stall = 2;
        drive(0, 1'b1, 4'h0, 24'h000010, 32'h0);
        drive(1, 1'b0, 4'hF, 24'h000020, 32'h0BADF00D);
        push(1'b0, 4'hF, 24'h000020, 32'h0BADF00D);
        push(1'b1, 4'h0, 24'h000010, 32'h0);
        #2;
        chk("t3_s_wmask", {60'd0, s_bus.wmask}, 64'hF);
        chk("t3_s_addr", {40'd0, s_bus.addr}, 64'h20);
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            #2;
            chk($sformatf("t3_m0_rbusy_t%0d", k), {63'd0, m0_bus.rbusy}, {63'd0, k <= 6});
            chk($sformatf("t3_s_rstrb_t%0d", k), {63'd0, s_bus.rstrb}, {63'd0, k == 4});
        end
        repeat (2) next_cycle();

        // Fairness: both masters request continuously; grants must alternate.
        do_reset();
        stall = 1;
        for (int k = 0; k < 10; k++) begin
            push(1'b0, 4'hF, 24'h002000 + 24'(4 * k), 32'(k));
            push(1'b1, 4'h0, 24'h001000 + 24'(4 * k), 32'h0);
        end
        n0 = 0; n1 = 0; p0 = 0; p1 = 0;
        for (int c = 0; c < 300 && (n0 < 10 || n1 < 10 || p0 || p1); c++) begin
            i0 = !p0 && n0 < 10;
            i1 = !p1 && n1 < 10;
            if (i0) drive(0, 1'b1, 4'h0, 24'h001000 + 24'(4 * n0), 32'h0);
            if (i1) drive(1, 1'b0, 4'hF, 24'h002000 + 24'(4 * n1), 32'(n1));
            #2;
            if (p0 && !m0_bus.rbusy) p0 = 0;
            if (p1 && !m1_bus.wbusy) p1 = 0;
            if (i0) begin p0 = 1; n0++; end
            if (i1) begin p1 = 1; n1++; end
            next_cycle();
        end
        chk("t4_done", {62'd0, p0, p1}, 64'd0);
        chk("t4_issued", 64'(n0 + n1), 64'd20);
        repeat (3) next_cycle();

        // Conflict during a stalled read: buffered write replays unchanged.
        do_reset();
        stall = 5;
        drive(0, 1'b1, 4'h0, 24'h000300, 32'h0);
        push(1'b1, 4'h0, 24'h000300, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            if (k == 2) begin
                drive(1, 1'b0, 4'b1100, 24'h000404, 32'hCAFEF00D);
                push(1'b0, 4'b1100, 24'h000404, 32'hCAFEF00D);
            end
            #2;
            chk($sformatf("t5_s_wmask_t%0d", k), {60'd0, s_bus.wmask}, (k == 7) ? 64'hC : 64'h0);
            if (k == 3) chk("t5_m1_wbusy", {63'd0, m1_bus.wbusy}, 64'd1);
            if (k == 7) begin
                chk("t5_s_addr", {40'd0, s_bus.addr}, 64'h404);
                chk("t5_s_wdata", {32'd0, s_bus.wdata}, 64'hCAFEF00D);
            end
        end
        repeat (8) next_cycle();

        // Reset while a read is stalled and M1 sits in its buffer.
        do_reset();
        stall = 5;
        drive(0, 1'b1, 4'h0, 24'h000500, 32'h0);
        push(1'b1, 4'h0, 24'h000500, 32'h0);
        next_cycle();
        drive(1, 1'b1, 4'h0, 24'h000600, 32'h0);
        next_cycle();
        #2;
        chk("t6_pre_busy", {62'd0, m0_bus.rbusy, m1_bus.rbusy}, 64'h3);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {60'd0, m0_bus.rbusy, m0_bus.wbusy, m1_bus.rbusy, m1_bus.wbusy}, 64'd0);
        chk("t6_rst_strobes", {59'd0, s_bus.rstrb, s_bus.wmask}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        stall = 0;
        repeat (5) next_cycle();
        drive(1, 1'b0, 4'b0001, 24'h000700, 32'h77777777);
        push(1'b0, 4'b0001, 24'h000700, 32'h77777777);
        #2;
        chk("t6_first_wmask", {60'd0, s_bus.wmask}, 64'h1);
        chk("t6_first_addr", {40'd0, s_bus.addr}, 64'h700);
        repeat (4) next_cycle();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
